// File: rtl/mt_pipe_pkg.sv
// Shared definitions for the multi-thread fetch pipeline: widths, reset PC and thread-ID sizing.
package mt_pipe_pkg;

  localparam int unsigned PC_WIDTH_DEFAULT = 9;
  localparam int unsigned START_PC_DEFAULT = 0;
  localparam logic [PC_WIDTH_DEFAULT-1:0] PC_MAX = '1;

  // Sequencer phase: the cycle after reset only arms fetching.
  typedef enum logic {
    PH_WAIT = 1'b0,
    PH_RUN  = 1'b1
  } phase_e;

  // Thread ID width; a single thread still needs one bit.
  function automatic int unsigned tid_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mt_fetch_sequencer_if.sv
// Fetch/redirect bundle between the fetch sequencer (master) and the pipeline (slave).
interface mt_fetch_sequencer_if
  import mt_pipe_pkg::*;
#(
  parameter int unsigned TID_WIDTH = 2,
  parameter int unsigned PC_WIDTH  = PC_WIDTH_DEFAULT
);
  logic                 redirect_valid;
  logic [TID_WIDTH-1:0] redirect_tid;
  logic [PC_WIDTH-1:0]  redirect_pc;
  logic                 fetch_valid;
  logic [TID_WIDTH-1:0] fetch_tid;
  logic [PC_WIDTH-1:0]  fetch_pc;

  modport master (
    input  redirect_valid, redirect_tid, redirect_pc,
    output fetch_valid, fetch_tid, fetch_pc
  );

  modport slave (
    output redirect_valid, redirect_tid, redirect_pc,
    input  fetch_valid, fetch_tid, fetch_pc
  );
endinterface

// File: rtl/rr_thread_arbiter.sv
// Combinational round-robin pick: first eligible thread strictly after ptr, wrapping to 0.
module rr_thread_arbiter
  import mt_pipe_pkg::*;
#(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned TID_WIDTH   = tid_width(NUM_THREADS)
) (
  input  logic [NUM_THREADS-1:0] eligible,
  input  logic [TID_WIDTH-1:0]   ptr,
  output logic                   grant_valid,
  output logic [TID_WIDTH-1:0]   grant_tid
);

  int unsigned idx;

  // Walk the rotated order ptr+1 .. ptr+NUM_THREADS and keep the first hit.
  always_comb begin
    grant_valid = 1'b0;
    grant_tid   = '0;
    idx         = 0;
    for (int unsigned k = 1; k <= NUM_THREADS; k++) begin
      idx = (32'(ptr) + k) % NUM_THREADS;
      if (!grant_valid && eligible[TID_WIDTH'(idx)]) begin
        grant_valid = 1'b1;
        grant_tid   = TID_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/mt_fetch_sequencer.sv
// Per-thread program counters with round-robin fetch issue, MEM-stage redirects, load mode and halt.
module mt_fetch_sequencer
  import mt_pipe_pkg::*;
#(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned TID_WIDTH   = tid_width(NUM_THREADS),
  parameter int unsigned PC_WIDTH    = PC_WIDTH_DEFAULT,
  parameter int unsigned START_PC    = START_PC_DEFAULT,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_mode,
  input  logic [NUM_THREADS-1:0] thread_en,
  input  logic                   stall,
  mt_fetch_sequencer_if.master   bus,
  output logic [NUM_THREADS-1:0] halted,
  output logic [CNT_WIDTH-1:0]   fetch_count
);

  localparam logic [PC_WIDTH-1:0]  PC_INIT = PC_WIDTH'(START_PC);
  localparam logic [PC_WIDTH-1:0]  PC_LAST = '1;
  localparam logic [TID_WIDTH-1:0] RR_INIT = TID_WIDTH'(NUM_THREADS - 1);

  phase_e               phase;
  logic [PC_WIDTH-1:0]  pc [NUM_THREADS];
  logic [TID_WIDTH-1:0] rr_ptr;
  logic                 fetch_valid_q;
  logic [TID_WIDTH-1:0] fetch_tid_q;
  logic [PC_WIDTH-1:0]  fetch_pc_q;

  logic [NUM_THREADS-1:0] eligible;
  logic                   grant_valid;
  logic [TID_WIDTH-1:0]   grant_tid;
  logic                   redirect_hit;

  assign eligible     = thread_en & ~halted;
  assign redirect_hit = bus.redirect_valid && (32'(bus.redirect_tid) < NUM_THREADS);

  rr_thread_arbiter #(
    .NUM_THREADS (NUM_THREADS),
    .TID_WIDTH   (TID_WIDTH)
  ) u_arb (
    .eligible    (eligible),
    .ptr         (rr_ptr),
    .grant_valid (grant_valid),
    .grant_tid   (grant_tid)
  );

  // Redirect is written after the increment so it wins on a same-thread collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase         <= PH_WAIT;
      for (int t = 0; t < int'(NUM_THREADS); t++) pc[t] <= PC_INIT;
      halted        <= '0;
      rr_ptr        <= RR_INIT;
      fetch_valid_q <= 1'b0;
      fetch_tid_q   <= '0;
      fetch_pc_q    <= PC_INIT;
      fetch_count   <= '0;
    end else if (load_mode) begin
      for (int t = 0; t < int'(NUM_THREADS); t++) pc[t] <= PC_INIT;
      halted        <= '0;
      rr_ptr        <= RR_INIT;
      fetch_valid_q <= 1'b0;
    end else begin
      if (!stall) begin
        if (phase == PH_WAIT) begin
          phase <= PH_RUN;
        end else if (grant_valid) begin
          fetch_valid_q <= 1'b1;
          fetch_tid_q   <= grant_tid;
          fetch_pc_q    <= pc[grant_tid];
          if (pc[grant_tid] == PC_LAST) halted[grant_tid] <= 1'b1;
          else pc[grant_tid] <= pc[grant_tid] + PC_WIDTH'(1);
          rr_ptr <= grant_tid;
          if (fetch_count != '1) fetch_count <= fetch_count + CNT_WIDTH'(1);
        end else begin
          fetch_valid_q <= 1'b0;
        end
      end
      if (redirect_hit) pc[bus.redirect_tid] <= bus.redirect_pc;
    end
  end

  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_tid   = fetch_tid_q;
  assign bus.fetch_pc    = fetch_pc_q;

endmodule

// File: tb/tb_mt_fetch_sequencer.sv
// Self-checking bench: vector table, directed corner sequences and random traffic vs a reference model.
module tb_mt_fetch_sequencer;

  localparam int N   = 4;
  localparam int PCW = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_mode;
  logic        stall;
  logic [3:0]  thread_en;
  logic [3:0]  halted;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  mt_fetch_sequencer_if #(.TID_WIDTH(2), .PC_WIDTH(PCW)) bus ();

  mt_fetch_sequencer #(
    .NUM_THREADS (N),
    .TID_WIDTH   (2),
    .PC_WIDTH    (PCW),
    .START_PC    (0),
    .CNT_WIDTH   (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_mode   (load_mode),
    .thread_en   (thread_en),
    .stall       (stall),
    .bus         (bus),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int     m_pc [N];
  bit     m_halt [N];
  int     m_rr;
  bit     m_started;
  bit     m_valid;
  int     m_tid;
  int     m_fpc;
  longint m_cnt;

  typedef struct {
    logic       rst;
    logic [3:0] en;
    logic       v;
    int         tid;
    int         pc;
    int         cnt;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Behavioural rules applied at one clock edge using the inputs presented to it.
  task automatic model_edge();
    int npc [N];
    int sel;
    if (reset) begin
      for (int t = 0; t < N; t++) begin m_pc[t] = 0; m_halt[t] = 0; end
      m_rr = N - 1; m_started = 0; m_valid = 0; m_tid = 0; m_fpc = 0; m_cnt = 0;
    end else if (load_mode) begin
      for (int t = 0; t < N; t++) begin m_pc[t] = 0; m_halt[t] = 0; end
      m_rr = N - 1; m_valid = 0;
    end else begin
      npc = m_pc;
      if (!stall) begin
        if (!m_started) begin
          m_started = 1;
        end else begin
          sel = -1;
          for (int k = 1; k <= N; k++) begin
            int t;
            t = (m_rr + k) % N;
            if (sel < 0 && thread_en[t] && !m_halt[t]) sel = t;
          end
          if (sel >= 0) begin
            m_valid = 1; m_tid = sel; m_fpc = m_pc[sel];
            if (m_pc[sel] == (1 << PCW) - 1) m_halt[sel] = 1;
            else npc[sel] = m_pc[sel] + 1;
            m_rr = sel;
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
          end else begin
            m_valid = 0;
          end
        end
      end
      if (bus.redirect_valid && int'(bus.redirect_tid) < N) npc[bus.redirect_tid] = int'(bus.redirect_pc);
      m_pc = npc;
    end
  endtask

  task automatic compare_model();
    logic [3:0] eh;
    for (int t = 0; t < N; t++) eh[t] = m_halt[t];
    chk("model_valid", 64'(bus.fetch_valid), 64'(m_valid));
    chk("model_tid", 64'(bus.fetch_tid), 64'(m_tid));
    chk("model_pc", 64'(bus.fetch_pc), 64'(m_fpc));
    chk("model_halted", 64'(halted), 64'(eh));
    chk("model_count", 64'(fetch_count), 64'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic expect_out(input string tag, input logic v, input int tid, input int pc,
                            input int cnt, input logic [3:0] hlt);
    chk({tag, "_valid"}, 64'(bus.fetch_valid), 64'(v));
    chk({tag, "_tid"}, 64'(bus.fetch_tid), 64'(tid));
    chk({tag, "_pc"}, 64'(bus.fetch_pc), 64'(pc));
    chk({tag, "_count"}, 64'(fetch_count), 64'(cnt));
    chk({tag, "_halted"}, 64'(halted), 64'(hlt));
  endtask

  task automatic do_reset();
    reset = 1'b1; load_mode = 1'b0; stall = 1'b0;
    bus.redirect_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic rst, input logic [3:0] en, input logic v,
                              input int tid, input int pc, input int cnt);
    vec_t r;
    r.rst = rst; r.en = en; r.v = v; r.tid = tid; r.pc = pc; r.cnt = cnt;
    return r;
  endfunction

  initial begin
    reset = 1'b1; load_mode = 1'b0; stall = 1'b0; thread_en = 4'b0000;
    bus.redirect_valid = 1'b0; bus.redirect_tid = '0; bus.redirect_pc = '0;

    // Round-robin, sparse enable and idle, straight from reset.
    tbl[0] = mk(1'b1, 4'b0000, 1'b0, 0, 0, 0);
    tbl[1] = mk(1'b0, 4'b1111, 1'b0, 0, 0, 0);
    for (int i = 0; i < 8; i++) tbl[2 + i] = mk(1'b0, 4'b1111, 1'b1, i % 4, i / 4, i + 1);
    tbl[10] = mk(1'b0, 4'b1010, 1'b1, 1, 2, 9);
    tbl[11] = mk(1'b0, 4'b1010, 1'b1, 3, 2, 10);
    tbl[12] = mk(1'b0, 4'b1010, 1'b1, 1, 3, 11);
    tbl[13] = mk(1'b0, 4'b1010, 1'b1, 3, 3, 12);
    tbl[14] = mk(1'b0, 4'b0000, 1'b0, 3, 3, 12);
    tbl[15] = mk(1'b0, 4'b0000, 1'b0, 3, 3, 12);
    for (int i = 0; i < 16; i++) begin
      reset = tbl[i].rst;
      thread_en = tbl[i].en;
      tick();
      expect_out($sformatf("tbl%0d", i), tbl[i].v, tbl[i].tid, tbl[i].pc, tbl[i].cnt, 4'b0000);
    end

    // Redirect colliding with selection of the same thread.
    do_reset();
    thread_en = 4'b1111;
    tick();
    tick();
    tick();
    bus.redirect_valid = 1'b1; bus.redirect_tid = 2'd2; bus.redirect_pc = 9'h040;
    tick();
    expect_out("coll_old", 1'b1, 2, 0, 3, 4'b0000);
    bus.redirect_valid = 1'b0;
    tick(); tick(); tick(); tick();
    expect_out("coll_new", 1'b1, 2, 9'h040, 7, 4'b0000);

    // Halt at the last address; redirect cannot revive, load mode can.
    do_reset();
    thread_en = 4'b0001;
    bus.redirect_valid = 1'b1; bus.redirect_tid = 2'd0; bus.redirect_pc = 9'h1FF;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    expect_out("halt_last", 1'b1, 0, 9'h1FF, 1, 4'b0001);
    tick();
    expect_out("halt_idle", 1'b0, 0, 9'h1FF, 1, 4'b0001);
    bus.redirect_valid = 1'b1; bus.redirect_tid = 2'd0; bus.redirect_pc = 9'h010;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    expect_out("halt_redir", 1'b0, 0, 9'h1FF, 1, 4'b0001);
    load_mode = 1'b1;
    tick();
    expect_out("halt_load", 1'b0, 0, 9'h1FF, 1, 4'b0000);
    load_mode = 1'b0;
    tick();
    expect_out("halt_restart", 1'b1, 0, 0, 2, 4'b0000);

    // Stall holds outputs; load mode overrides stall.
    do_reset();
    thread_en = 4'b1111;
    tick(); tick(); tick(); tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("stall%0d", i), 1'b1, 2, 0, 3, 4'b0000);
    end
    load_mode = 1'b1;
    tick();
    expect_out("stall_load", 1'b0, 2, 0, 3, 4'b0000);
    load_mode = 1'b0; stall = 1'b0;
    tick();
    expect_out("load_exit", 1'b1, 0, 0, 4, 4'b0000);

    // Reset in the middle of a run.
    do_reset();
    thread_en = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) tick();
    expect_out("pre_rst", 1'b1, 0, 1, 5, 4'b0000);
    reset = 1'b1;
    tick();
    expect_out("mid_rst", 1'b0, 0, 0, 0, 4'b0000);
    reset = 1'b0;
    tick();
    expect_out("rst_wait", 1'b0, 0, 0, 0, 4'b0000);
    tick();
    expect_out("rst_first", 1'b1, 0, 0, 1, 4'b0000);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom % 100) < 2;
      load_mode = ($urandom % 100) < 4;
      stall     = ($urandom % 8) == 0;
      if (($urandom % 16) == 0) thread_en = 4'($urandom);
      bus.redirect_valid = ($urandom % 4) == 0;
      bus.redirect_tid   = 2'($urandom);
      bus.redirect_pc    = (($urandom % 4) == 0) ? 9'(9'h1F0 + 9'($urandom % 16)) : 9'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
